// File: rtl/mac_accum4.sv
// mac_accum4: signed 4-bit multiply-accumulate over N_TERMS accepted terms,
// followed by an arithmetic right-shift scale and saturation to 4 bits.
// Y/ovfl are held between done pulses so a downstream rectifier can read
// them combinationally at any time.
module mac_accum4 #(
    parameter int N_TERMS = 4,
    parameter int ACC_W   = 12,
    parameter int SHIFT   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_vld,
    input  logic signed [3:0] A,
    input  logic signed [3:0] B,
    output logic              busy,
    output logic              done,
    output logic [3:0]        Y,
    output logic              ovfl
);

    localparam int CNT_W = (N_TERMS > 2) ? $clog2(N_TERMS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(7);
    localparam logic signed [ACC_W-1:0] MINV = -ACC_W'(8);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t                   state, state_nx;
    logic signed [ACC_W-1:0]  acc, acc_nx;
    logic [CNT_W-1:0]         cnt, cnt_nx;
    logic [3:0]               y_nx;
    logic                     ovfl_nx, done_nx;

    logic signed [7:0]        prod;
    logic signed [ACC_W-1:0]  prod_ext, sum, scaled;
    logic                     clip_hi, clip_lo;

    // Full 8-bit signed product; operands sign-extended so the multiply is exact.
    assign prod     = $signed({{4{A[3]}}, A}) * $signed({{4{B[3]}}, B});
    assign prod_ext = {{(ACC_W-8){prod[7]}}, prod};
    assign sum      = acc + prod_ext;
    assign scaled   = sum >>> SHIFT;
    assign clip_hi  = scaled > MAXV;
    assign clip_lo  = scaled < MINV;

    // busy is simply the registered state decode.
    assign busy = (state == ACCUM);

    // State and datapath registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            Y     <= 4'b0000;
            ovfl  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            Y     <= y_nx;
            ovfl  <= ovfl_nx;
            done  <= done_nx;
        end
    end

    // Next-state: start wins over in_vld; the final accepted term publishes
    // the saturated result and returns to IDLE.
    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        cnt_nx   = cnt;
        y_nx     = Y;
        ovfl_nx  = ovfl;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = ACCUM;
                end
            end
            ACCUM: begin
                if (start) begin
                    acc_nx = '0;
                    cnt_nx = '0;
                end else if (in_vld) begin
                    if (cnt == LAST) begin
                        if (clip_hi)      y_nx = 4'b0111;
                        else if (clip_lo) y_nx = 4'b1000;
                        else              y_nx = scaled[3:0];
                        ovfl_nx  = clip_hi | clip_lo;
                        done_nx  = 1'b1;
                        acc_nx   = '0;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        acc_nx = sum;
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: doc/mac_accum4.md
Name: mac_accum4

Overview:
Signed 4-bit multiply-accumulate stage that sits directly upstream of the 4-bit ReLU rectifier. It accumulates N_TERMS products A*B, accepting one term per valid cycle. It then applies an arithmetic right-shift scale and saturates the sum to a 4-bit signed result Y, which drives the rectifier's Y input. A one-cycle done pulse and an overflow flag accompany each result.

Parameters:
N_TERMS, 4, number of accepted A*B products per result (range 2..16)
ACC_W, 12, accumulator width in bits; must be >= 9 + clog2(N_TERMS)
SHIFT, 0, arithmetic right shift applied to the final sum before saturation (range 0..ACC_W-4)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin (or restart) an accumulation
in_vld  input  1  A/B carry a valid term this cycle
A  input  4  signed operand, two's complement
B  input  4  signed operand, two's complement
busy  output  1  high while in ACCUM
done  output  1  single-cycle pulse: Y/ovfl updated with a new result
Y  output  4  signed saturated result, held until the next done
ovfl  output  1  1 if the latest result was clipped, held with Y

Behaviour:
- Reset (async, rst_n low): state=IDLE, acc=0, cnt=0, Y=4'b0000, done=0, busy=0, ovfl=0. Takes effect immediately, including mid-accumulation.
- Product: 8-bit signed A*B, range -56..+64. It is sign-extended to ACC_W before it is added. The accumulator never wraps within the legal parameter range.
- FSM states: IDLE, ACCUM.
- IDLE:
  - in_vld is ignored.
  - start=1 gives acc<=0, cnt<=0, ->ACCUM.
  - The in_vld term in the same cycle as start is NOT accepted.
- ACCUM:
  - busy=1 (registered, equal to state==ACCUM).
  - in_vld=1 accepts the term: acc<=acc+prod, cnt<=cnt+1.
  - in_vld=0 is a bubble: acc and cnt hold, and there is no timeout.
  - start=1 has priority over in_vld and restarts: acc<=0, cnt<=0, stay in ACCUM, term dropped. Y/ovfl are untouched.
  - Final term is the accepted term with cnt==N_TERMS-1. On that edge:
    - sum = acc+prod (combinational).
    - Y <= sat4(sum >>> SHIFT).
    - ovfl <= 1 if clipped, else 0.
    - done<=1, acc<=0, cnt<=0, ->IDLE.
- Latency: done and the new Y are visible in the cycle after the final accepted term. busy drops in that same cycle.
- done is high for exactly one cycle; otherwise 0.
- sat4: the value is clamped to the range -8..+7.
  - Values > 7 give 4'b0111.
  - Values < -8 give 4'b1000.
  - Otherwise the low 4 bits are passed through.
- Back-to-back operation: start may be asserted in the cycle done is high. FSM is IDLE then, so a new accumulation begins.
- Y is stable between done pulses, so the downstream rectifier may sample it combinationally at any time.

Test Plan:
- Reset mid-op: start, accept 2 terms (3,2),(1,1), assert rst_n=0 -> busy=0, done=0, Y=0000, ovfl=0 immediately. Then start with terms (1,1)x4 -> Y=0100, confirming no leftover acc.
- Basic sum: start, then terms (1,1),(2,1),(1,2),(0,3) on consecutive cycles -> done high exactly one cycle after 4th term, Y=0101, ovfl=0, busy low that cycle.
- Negative saturate: terms (-1,3)x4 (sum -12) -> Y=1000, ovfl=1. Then terms (-1,1),(0,0),(0,0),(0,0) -> Y=1111, ovfl=0.
- Positive saturate / extreme product: terms (-8,-8)x4 (sum 256) -> Y=0111, ovfl=1. No wrap, so acc width is exercised.
- Bubbles and ignored inputs:
  - in_vld pulses in IDLE and in the start cycle are not counted.
  - 4 terms (1,1) spread with 0-3 idle cycles between -> done one cycle after the 4th accepted term, Y=0100.
- Restart mid-op: after 3 terms (2,2), assert start with in_vld=1 and (3,3) -> dropped. Then 4 terms (1,1) -> Y=0100, ovfl=0. With SHIFT=2 build, terms (2,2)x4 (sum 16) -> Y=0100.
